// File: rtl/posit_lut_pkg.sv
// Shared definitions for the runtime-loadable posit lookup table.
// Optional build macro: POSIT_LUT_LOADER_CHECKSUM_EN (see posit_lut_loader.sv).
package posit_lut_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } lut_state_t;

  // Width of the load checksum accumulator
  localparam int CSUM_W = 16;

  // NaR pattern for a posit of the given width: sign bit set, all others clear
  function automatic logic [31:0] nar(input int width);
    nar = 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/posit_lut_ram.sv
// Table storage: 2**WIDTH x WIDTH, one synchronous write port and one
// synchronous read port. Contents are not reset; the read register holds
// its value while no read is requested.
module posit_lut_ram
  import posit_lut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**WIDTH];
  logic [WIDTH-1:0] r_rdata;

  // Write on request; registered read, held while idle
  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/posit_lut_loader.sv
// Runtime-writable posit unary-function lookup table. The host streams all
// 2**WIDTH entries in ascending address order; lookups return NaR until a
// complete table has been loaded.
// Optional build macro: POSIT_LUT_LOADER_CHECKSUM_EN enables the 16-bit sum of
// loaded entries on o_load_checksum; without it the port is tied to zero.
//
// Load handshake: an entry transfers on a rising edge iff i_load_valid and
// o_load_ready are both high and i_load_start is low in that cycle (a restart
// discards a coincident entry). o_load_ready is high for the whole LOAD state
// and depends only on the FSM state, never on the inputs.
module posit_lut_loader
  import posit_lut_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ES    = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_load_start,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  output logic              o_load_busy,
  output logic              o_load_done,
  output logic              o_table_valid,
  output logic [CSUM_W-1:0] o_load_checksum,
  input  logic              i_lookup_valid,
  input  logic [WIDTH-1:0]  i_lookup_in,
  output logic              o_lookup_out_valid,
  output logic [WIDTH-1:0]  o_lookup_out,
  output lut_state_t        o_dbg_state
);

  localparam logic [WIDTH-1:0] NAR_VAL   = WIDTH'(nar(WIDTH));
  localparam logic [WIDTH-1:0] LAST_ADDR = '1;

  // ES only selects which function the host loads; reject nonsense values
  if (ES < 0 || ES > WIDTH - 2) begin : g_bad_es
    $error("posit_lut_loader: ES out of range for WIDTH");
  end

  lut_state_t       r_state;
  lut_state_t       w_next_state;
  logic             w_load_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] r_addr;
  logic             r_done;
  logic             r_table_valid;
  logic             r_lookup_valid;
  logic             r_out_seen;
  logic             r_use_nar;
  logic [WIDTH-1:0] w_ram_rdata;

  // FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state, ready and transfer qualification
  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_xfer       = 1'b0;
    if (r_state == ST_LOAD) w_load_ready = 1'b1;
    w_xfer = w_load_ready & i_load_valid & ~i_load_start;
    if (i_load_start)                        w_next_state = ST_LOAD;
    else if (w_xfer && r_addr == LAST_ADDR)  w_next_state = ST_READY;
  end

  // Address counter, done pulse and table-valid flag
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr        <= '0;
      r_done        <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load_start) begin
        r_addr        <= '0;
        r_table_valid <= 1'b0;
      end else if (w_xfer) begin
        r_addr <= r_addr + 1'b1;
        if (r_addr == LAST_ADDR) begin
          r_done        <= 1'b1;
          r_table_valid <= 1'b1;
        end
      end
    end
  end

`ifdef POSIT_LUT_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] r_csum;

  // Running sum of accepted entries, cleared when a load (re)starts
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)           r_csum <= '0;
    else if (i_load_start) r_csum <= '0;
    else if (w_xfer)       r_csum <= r_csum + CSUM_W'(i_load_data);
  end

  assign o_load_checksum = r_csum;
`else
  assign o_load_checksum = '0;
`endif

  // Lookup bookkeeping: result-valid delay and whether the result must be NaR
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lookup_valid <= 1'b0;
      r_out_seen     <= 1'b0;
      r_use_nar      <= 1'b0;
    end else begin
      r_lookup_valid <= i_lookup_valid;
      if (i_lookup_valid) begin
        r_out_seen <= 1'b1;
        r_use_nar  <= ~r_table_valid;
      end
    end
  end

  posit_lut_ram #(.WIDTH(WIDTH)) u_ram (
    .i_clock (i_clock),
    .i_we    (w_xfer),
    .i_waddr (r_addr),
    .i_wdata (i_load_data),
    .i_re    (i_lookup_valid),
    .i_raddr (i_lookup_in),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register is unreset, so the output shows zero until the first lookup
  assign o_lookup_out       = !r_out_seen ? '0 : (r_use_nar ? NAR_VAL : w_ram_rdata);
  assign o_lookup_out_valid = r_lookup_valid;
  assign o_load_ready       = w_load_ready;
  assign o_load_busy        = (r_state == ST_LOAD);
  assign o_load_done        = r_done;
  assign o_table_valid      = r_table_valid;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_posit_lut_loader.sv
// Bench for posit_lut_loader (WIDTH=8, ES=1): loads identity, sqrt and random
// tables with and without valid gaps, restarts and resets mid-load, and checks
// lookups against a table model held in the bench.
module tb_posit_lut_loader;
  import posit_lut_pkg::*;

  localparam int W = 8;
  localparam int N = 256;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_load_start;
  logic [W-1:0]  i_load_data;
  logic          i_load_valid;
  logic          o_load_ready;
  logic          o_load_busy;
  logic          o_load_done;
  logic          o_table_valid;
  logic [15:0]   o_load_checksum;
  logic          i_lookup_valid;
  logic [W-1:0]  i_lookup_in;
  logic          o_lookup_out_valid;
  logic [W-1:0]  o_lookup_out;
  lut_state_t    o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] src_tab [N];
  logic [W-1:0] model   [N];
  bit           model_valid = 1'b0;

  posit_lut_loader #(.WIDTH(W), .ES(1)) dut (
    .i_clock            (clk),
    .i_reset            (i_reset),
    .i_load_start       (i_load_start),
    .i_load_data        (i_load_data),
    .i_load_valid       (i_load_valid),
    .o_load_ready       (o_load_ready),
    .o_load_busy        (o_load_busy),
    .o_load_done        (o_load_done),
    .o_table_valid      (o_table_valid),
    .o_load_checksum    (o_load_checksum),
    .i_lookup_valid     (i_lookup_valid),
    .i_lookup_in        (i_lookup_in),
    .o_lookup_out_valid (o_lookup_out_valid),
    .o_lookup_out       (o_lookup_out),
    .o_dbg_state        (o_dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // posit<8,1> value of a positive pattern 0x01..0x7F
  function automatic real p8_decode(input logic [7:0] p);
    int i, m, k, e, sc;
    logic r;
    real f, v;
    r = p[6]; i = 6; m = 0;
    while (i >= 0 && p[i] == r) begin m++; i--; end
    i--;
    k = r ? m - 1 : -m;
    e = 0;
    if (i >= 0) begin e = p[i] ? 1 : 0; i--; end
    f = 0.0;
    for (int j = 0; j <= i; j++) f = (f + (p[j] ? 1.0 : 0.0)) / 2.0;
    v = 1.0 + f;
    sc = 2 * k + e;
    if (sc > 0) for (int j = 0; j < sc; j++) v = v * 2.0;
    else        for (int j = 0; j < -sc; j++) v = v / 2.0;
    return v;
  endfunction

  // nearest positive posit<8,1> pattern to v
  function automatic logic [7:0] p8_encode(input real v);
    logic [7:0] best;
    real bd, d;
    best = 8'h01;
    bd = p8_decode(8'h01) - v; if (bd < 0) bd = -bd;
    for (int q = 2; q < 128; q++) begin
      d = p8_decode(8'(q)) - v; if (d < 0) d = -d;
      if (d < bd) begin bd = d; best = 8'(q); end
    end
    return best;
  endfunction

  task automatic fill_identity();
    for (int i = 0; i < N; i++) src_tab[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) src_tab[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_sqrt();
    for (int i = 0; i < N; i++) begin
      if (i == 0)        src_tab[i] = 8'h00;
      else if (i >= 128) src_tab[i] = 8'h80;
      else               src_tab[i] = p8_encode($sqrt(p8_decode(8'(i))));
    end
  endtask

  // Starts a load (with a coincident valid entry that must be discarded) and
  // streams src_tab[0..stop_at-1]; a full load also checks completion.
  task automatic load_table(input bit gaps, input int stop_at, input string tag);
    int idx, cyc, early_done, early_tv;
    logic [31:0] sum;
    bit v;
    i_load_start = 1'b1;
    i_load_valid = 1'b1;
    i_load_data  = 8'($urandom_range(0, 255));
    model_valid  = 1'b0;
    @(negedge clk);
    i_load_start = 1'b0;
    check({tag, "_start_ready"}, o_load_ready, 1);
    check({tag, "_start_busy"}, o_load_busy, 1);
    check({tag, "_start_tv"}, o_table_valid, 0);
    check({tag, "_start_csum"}, o_load_checksum, 0);
    check({tag, "_start_state"}, o_dbg_state, ST_LOAD);
    idx = 0; cyc = 0; early_done = 0; early_tv = 0; sum = 0;
    while (idx < stop_at && cyc < 3000) begin
      if (o_load_done)   early_done++;
      if (o_table_valid) early_tv++;
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_load_valid = v;
      i_load_data  = src_tab[idx];
      if (v && o_load_ready) begin
        sum = sum + 32'(src_tab[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_count"}, idx, stop_at);
    check({tag, "_early_done"}, early_done, 0);
    check({tag, "_early_tv"}, early_tv, 0);
    if (stop_at == N) begin
      i_load_valid = 1'b0;
      check({tag, "_done"}, o_load_done, 1);
      check({tag, "_tv"}, o_table_valid, 1);
`ifdef POSIT_LUT_LOADER_CHECKSUM_EN
      check({tag, "_csum"}, o_load_checksum, sum & 32'hFFFF);
`else
      check({tag, "_csum"}, o_load_checksum, 0);
`endif
      check({tag, "_state"}, o_dbg_state, ST_READY);
      for (int i = 0; i < N; i++) model[i] = src_tab[i];
      model_valid = 1'b1;
      @(negedge clk);
      check({tag, "_done_pulse"}, o_load_done, 0);
      check({tag, "_ready_drop"}, o_load_ready, 0);
      check({tag, "_busy_drop"}, o_load_busy, 0);
      check({tag, "_tv_hold"}, o_table_valid, 1);
    end
  endtask

  task automatic do_lookup(input logic [7:0] a, input string tag);
    logic [7:0] e;
    e = model_valid ? model[a] : 8'h80;
    i_lookup_valid = 1'b1;
    i_lookup_in    = a;
    @(negedge clk);
    i_lookup_valid = 1'b0;
    i_lookup_in    = 8'($urandom_range(0, 255));
    check({tag, "_v"}, o_lookup_out_valid, 1);
    check(tag, o_lookup_out, e);
    @(negedge clk);
    check({tag, "_idle_v"}, o_lookup_out_valid, 0);
    check({tag, "_hold"}, o_lookup_out, e);
  endtask

  task automatic random_lookups(input int n, input string tag);
    for (int i = 0; i < n; i++) do_lookup(8'($urandom_range(0, 255)), tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, o_load_ready, 0);
    check({tag, "_busy"}, o_load_busy, 0);
    check({tag, "_done"}, o_load_done, 0);
    check({tag, "_tv"}, o_table_valid, 0);
    check({tag, "_lv"}, o_lookup_out_valid, 0);
    check({tag, "_lo"}, o_lookup_out, 0);
    check({tag, "_csum"}, o_load_checksum, 0);
    check({tag, "_state"}, o_dbg_state, ST_IDLE);
  endtask

  initial begin
    i_reset = 1'b1; i_load_start = 1'b0; i_load_data = '0; i_load_valid = 1'b0;
    i_lookup_valid = 1'b0; i_lookup_in = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    i_reset = 1'b0;
    @(negedge clk);

    // 1: lookup before any table
    do_lookup(8'h40, "nar_before_load");
    check("nar_const", o_lookup_out, 8'h80);

    // 2: identity table, valid held high
    fill_identity();
    load_table(1'b0, N, "ident");
    do_lookup(8'h40, "ident_40");
    check("ident_40_const", o_lookup_out, 8'h40);
    do_lookup(8'h00, "ident_00");
    do_lookup(8'hFF, "ident_ff");
    random_lookups(8, "ident_rnd");

    // 3: sqrt table
    fill_sqrt();
    load_table(1'b0, N, "sqrt");
    do_lookup(8'h60, "sqrt_60");
    check("sqrt_4_is_2", o_lookup_out, 8'h50);
    do_lookup(8'h40, "sqrt_40");
    check("sqrt_1_is_1", o_lookup_out, 8'h40);
    do_lookup(8'h80, "sqrt_80");
    check("sqrt_nar", o_lookup_out, 8'h80);
    random_lookups(8, "sqrt_rnd");

    // 4: identity with random valid gaps
    fill_identity();
    load_table(1'b1, N, "gaps");
    random_lookups(12, "gaps_rnd");

    // 5: restart after 100 entries
    fill_random();
    load_table(1'b1, 100, "part100");
    do_lookup(8'h05, "part100_nar");
    fill_random();
    load_table(1'b1, N, "restart");
    random_lookups(12, "restart_rnd");

    // 6: reset at entry 200
    fill_random();
    load_table(1'b0, 200, "part200");
    i_reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    i_reset = 1'b0;
    i_load_valid = 1'b0;
    model_valid = 1'b0;
    @(negedge clk);
    do_lookup(8'h40, "midrst_nar");
    do_lookup(8'hC3, "midrst_nar2");
    fill_random();
    load_table(1'b1, N, "reload");
    random_lookups(12, "reload_rnd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
